// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared LSU types. The memory-op kind is used by both the
//                memory-op selector and the memory port. The memory port FSM
//                state type also lives here.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic {
        MEM_OP_LOAD  = 1'b0,
        MEM_OP_STORE = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_port_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_memory_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_memory_port_if
//  Description : Data-memory bus carrying a valid/ready request channel and
//                a valid-only load response channel.
//                  mem_req_valid/ready  request handshake
//                  mem_req_write        1 = store
//                  mem_req_addr/wdata   request address / store data
//                  mem_resp_valid/rdata load data returning
//                The master modport is the LSU side; the slave modport is
//                the memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface lsu_memory_port_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_write;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_memory_port.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_memory_port
//  Description : Registered bridge between the LSU memory-op selector and the
//                data-memory bus. It holds one load or store at a time.
//                Completions come back tagged with the LDQ/STQ index, and
//                load results killed by a flush are suppressed.
//  Ports       : clk, reset (async, active-high)
//                fire_memory_op, memory_op_type, memory_address, memory_data,
//                ldq_mem_stage_index, stq_mem_stage_index : selector issue
//                flush        : kills an outstanding load
//                port_ready   : a fire is accepted this cycle (state == IDLE)
//                mem          : memory bus (master side)
//                load_result_* : one-cycle load completion
//                store_done_*  : one-cycle store completion
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_memory_port
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LDQ_SIZE = 32,
    parameter int STQ_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fire_memory_op,
    input  mem_op_t                     memory_op_type,
    input  logic [XLEN-1:0]             memory_address,
    input  logic [XLEN-1:0]             memory_data,
    input  logic [$clog2(LDQ_SIZE)-1:0] ldq_mem_stage_index,
    input  logic [$clog2(STQ_SIZE)-1:0] stq_mem_stage_index,
    input  logic                        flush,
    output logic                        port_ready,
    lsu_memory_port_if.master           mem,
    output logic                        load_result_valid,
    output logic [$clog2(LDQ_SIZE)-1:0] load_result_index,
    output logic [XLEN-1:0]             load_result_data,
    output logic                        store_done_valid,
    output logic [$clog2(STQ_SIZE)-1:0] store_done_index
);

    localparam int c_LDQ_W = $clog2(LDQ_SIZE);
    localparam int c_STQ_W = $clog2(STQ_SIZE);

    lsu_port_state_t     r_state;
    lsu_port_state_t     w_state_next;
    logic                w_accept_fire;
    logic                w_req_accepted;
    logic                w_resp_take;

    mem_op_t             r_op;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [c_LDQ_W-1:0]  r_ldq_idx;
    logic [c_STQ_W-1:0]  r_stq_idx;
    logic                r_killed;
    logic                r_req_valid;
    logic                r_store_done_valid;
    logic [c_STQ_W-1:0]  r_store_done_index;
    logic                r_load_result_valid;
    logic [c_LDQ_W-1:0]  r_load_result_index;
    logic [XLEN-1:0]     r_load_result_data;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept_fire  = 1'b0;
        w_req_accepted = 1'b0;
        w_resp_take    = 1'b0;
        case (r_state)
            IDLE: begin
                // A load issued together with a flush is already dead, so it
                // never reaches memory. Stores are committed and always go out.
                if (fire_memory_op &&
                    !(memory_op_type == MEM_OP_LOAD && flush)) begin
                    w_accept_fire = 1'b1;
                    w_state_next  = REQ;
                end
            end
            REQ: begin
                // A killed load still finishes its handshake so that valid is
                // never withdrawn while memory may be sampling it.
                if (mem.mem_req_ready) begin
                    w_req_accepted = 1'b1;
                    w_state_next   = (r_op == MEM_OP_STORE) ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_resp_valid) begin
                    w_resp_take  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ datapath/outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op                <= MEM_OP_LOAD;
            r_addr              <= '0;
            r_wdata             <= '0;
            r_ldq_idx           <= '0;
            r_stq_idx           <= '0;
            r_killed            <= 1'b0;
            r_req_valid         <= 1'b0;
            r_store_done_valid  <= 1'b0;
            r_store_done_index  <= '0;
            r_load_result_valid <= 1'b0;
            r_load_result_index <= '0;
            r_load_result_data  <= '0;
        end else begin
            r_req_valid         <= (w_state_next == REQ);
            r_store_done_valid  <= w_req_accepted && (r_op == MEM_OP_STORE);
            // A flush arriving with the response kills the load too.
            r_load_result_valid <= w_resp_take && !(r_killed || flush);

            if (w_accept_fire) begin
                r_op    <= memory_op_type;
                r_addr  <= memory_address;
                r_wdata <= memory_data;
                if (memory_op_type == MEM_OP_LOAD) begin
                    r_ldq_idx <= ldq_mem_stage_index;
                end else begin
                    r_stq_idx <= stq_mem_stage_index;
                end
            end

            if (w_req_accepted && (r_op == MEM_OP_STORE)) begin
                r_store_done_index <= r_stq_idx;
            end

            if (w_resp_take) begin
                r_load_result_index <= r_ldq_idx;
                r_load_result_data  <= mem.mem_resp_rdata;
            end

            if (w_state_next == IDLE) begin
                r_killed <= 1'b0;
            end else if (flush && (r_state != IDLE) && (r_op == MEM_OP_LOAD)) begin
                r_killed <= 1'b1;
            end
        end
    end

    assign port_ready         = (r_state == IDLE);
    assign mem.mem_req_valid  = r_req_valid;
    assign mem.mem_req_write  = (r_op == MEM_OP_STORE);
    assign mem.mem_req_addr   = r_addr;
    assign mem.mem_req_wdata  = r_wdata;
    assign load_result_valid  = r_load_result_valid;
    assign load_result_index  = r_load_result_index;
    assign load_result_data   = r_load_result_data;
    assign store_done_valid   = r_store_done_valid;
    assign store_done_index   = r_store_done_index;

    // The selector must not issue while the port is busy. Such a fire is
    // dropped, and this check flags the offending cycle.
    a_fire_when_busy : assert property (@(posedge clk) disable iff (reset)
        !(fire_memory_op && (r_state != IDLE)))
        else $warning("lsu_memory_port: fire_memory_op while port busy, op ignored");

endmodule
`default_nettype wire

// File: tb/tb_lsu_memory_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_memory_port
//  Description : Self-checking bench for lsu_memory_port. It applies a
//                hand-written vector table, then hand sequences for reset,
//                then random transactions checked against a
//                transaction-level rule model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_memory_port;
    import lsu_pkg::*;

    localparam int XLEN = 32;
    localparam int IW   = 5;

    typedef struct {
        mem_op_t         op;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [IW-1:0]   idx;
        logic            flush_fire; // flush in the fire cycle
        int              stall;      // cycles of ready=0 before acceptance
        int              resp_dly;   // cycles from acceptance to response (>=1)
        int              flush_k;    // cycle (after fire) flush is driven, 0 = none
        int              refire_k;   // cycle an illegal fire is driven, 0 = none
        logic [XLEN-1:0] rdata;
        logic            exp_req;
        logic            exp_done;
        logic            exp_res;
        int              exp_lat;    // cycles from fire to port_ready
    } vec_t;

    logic                clk;
    logic                reset;
    logic                fire_memory_op;
    mem_op_t             memory_op_type;
    logic [XLEN-1:0]     memory_address;
    logic [XLEN-1:0]     memory_data;
    logic [IW-1:0]       ldq_mem_stage_index;
    logic [IW-1:0]       stq_mem_stage_index;
    logic                flush;
    logic                port_ready;
    logic                load_result_valid;
    logic [IW-1:0]       load_result_index;
    logic [XLEN-1:0]     load_result_data;
    logic                store_done_valid;
    logic [IW-1:0]       store_done_index;

    lsu_memory_port_if #(.XLEN(XLEN)) mem_if ();

    lsu_memory_port #(.XLEN(XLEN), .LDQ_SIZE(32), .STQ_SIZE(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fire_memory_op      (fire_memory_op),
        .memory_op_type      (memory_op_type),
        .memory_address      (memory_address),
        .memory_data         (memory_data),
        .ldq_mem_stage_index (ldq_mem_stage_index),
        .stq_mem_stage_index (stq_mem_stage_index),
        .flush               (flush),
        .port_ready          (port_ready),
        .mem                 (mem_if.master),
        .load_result_valid   (load_result_valid),
        .load_result_index   (load_result_index),
        .load_result_data    (load_result_data),
        .store_done_valid    (store_done_valid),
        .store_done_index    (store_done_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(mem_op_t op, logic [31:0] addr, logic [31:0] wd,
                                logic [4:0] idx, logic ff, int s, int d, int fk, int rk,
                                logic [31:0] rd, logic er, logic ed, logic es, int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wd; v.idx = idx; v.flush_fire = ff;
        v.stall = s; v.resp_dly = d; v.flush_k = fk; v.refire_k = rk; v.rdata = rd;
        v.exp_req = er; v.exp_done = ed; v.exp_res = es; v.exp_lat = lat;
        return v;
    endfunction

    // Rule-level outcome of one transaction: a load issued with flush is
    // dropped; a load is killed by any flush up to and including its response
    // cycle; stores ignore flush. Latency = issue + stall + handshake + result.
    function automatic vec_t model(vec_t v);
        bit dropped = (v.op == MEM_OP_LOAD) && v.flush_fire;
        bit killed  = (v.flush_k >= 1) && (v.flush_k <= v.stall + 1 + v.resp_dly);
        v.exp_req  = !dropped;
        v.exp_done = (v.op == MEM_OP_STORE);
        v.exp_res  = (v.op == MEM_OP_LOAD) && !dropped && !killed;
        if (dropped)                  v.exp_lat = 1;
        else if (v.op == MEM_OP_STORE) v.exp_lat = v.stall + 2;
        else                          v.exp_lat = v.stall + v.resp_dly + 2;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int  k;
        bit  finished;
        check("idle_port_ready", port_ready, 1);
        fire_memory_op      = 1'b1;
        memory_op_type      = v.op;
        memory_address      = v.addr;
        memory_data         = v.wdata;
        ldq_mem_stage_index = (v.op == MEM_OP_LOAD)  ? v.idx : IW'($urandom);
        stq_mem_stage_index = (v.op == MEM_OP_STORE) ? v.idx : IW'($urandom);
        flush               = v.flush_fire;
        tick();
        fire_memory_op = 1'b0;
        flush          = 1'b0;
        k = 1;
        finished = 0;
        while (!finished) begin
            check("req_valid", mem_if.mem_req_valid, v.exp_req && (k <= v.stall + 1));
            if (mem_if.mem_req_valid) begin
                check("req_write", mem_if.mem_req_write, (v.op == MEM_OP_STORE));
                check("req_addr", mem_if.mem_req_addr, v.addr);
                if (v.op == MEM_OP_STORE) check("req_wdata", mem_if.mem_req_wdata, v.wdata);
            end
            check("store_done_valid", store_done_valid, v.exp_done && (k == v.exp_lat));
            check("load_result_valid", load_result_valid, v.exp_res && (k == v.exp_lat));
            if (store_done_valid) check("store_done_index", store_done_index, v.idx);
            if (load_result_valid) begin
                check("load_result_index", load_result_index, v.idx);
                check("load_result_data", load_result_data, v.rdata);
            end
            if (port_ready) begin
                check("latency", k, v.exp_lat);
                finished = 1;
            end else if (k >= 40) begin
                n_vec++;
                n_bad++;
                $display("FAIL timeout: port_ready still 0 after %0d cycles, expected %0d", k, v.exp_lat);
                finished = 1;
            end else begin
                mem_if.mem_req_ready  = (k > v.stall);
                mem_if.mem_resp_valid = (k == v.stall + 1 + v.resp_dly);
                mem_if.mem_resp_rdata = mem_if.mem_resp_valid ? v.rdata : $urandom;
                flush                 = (k == v.flush_k);
                if (k == v.refire_k) begin
                    fire_memory_op      = 1'b1;
                    memory_op_type      = (v.op == MEM_OP_LOAD) ? MEM_OP_STORE : MEM_OP_LOAD;
                    memory_address      = ~v.addr;
                    memory_data         = ~v.wdata;
                    ldq_mem_stage_index = ~v.idx;
                    stq_mem_stage_index = ~v.idx;
                end
                tick();
                fire_memory_op = 1'b0;
                k++;
            end
        end
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        flush                 = 1'b0;
        tick();
        check("pulse_clear_store", store_done_valid, 0);
        check("pulse_clear_load", load_result_valid, 0);
        check("req_clear", mem_if.mem_req_valid, 0);
        check("back_to_idle", port_ready, 1);
    endtask

    vec_t vecs[11];

    initial begin
        vec_t v;
        // op, addr, wdata, idx, ffire, stall, dly, flush_k, refire_k, rdata, req, done, res, lat
        vecs[0]  = mk(MEM_OP_STORE, 32'h100, 32'hDEADBEEF, 5'd5,  0, 0, 1, 0, 0, 32'h0,        1, 1, 0, 2);
        vecs[1]  = mk(MEM_OP_LOAD,  32'h200, 32'h0,        5'd7,  0, 3, 2, 0, 0, 32'h12345678, 1, 0, 1, 7);
        vecs[2]  = mk(MEM_OP_LOAD,  32'h300, 32'h0,        5'd12, 0, 0, 2, 2, 0, 32'hCAFEF00D, 1, 0, 0, 4);
        vecs[3]  = mk(MEM_OP_LOAD,  32'h400, 32'h0,        5'd1,  1, 0, 1, 0, 0, 32'h0,        0, 0, 0, 1);
        vecs[4]  = mk(MEM_OP_STORE, 32'h500, 32'h0BADF00D, 5'd31, 1, 0, 1, 0, 0, 32'h0,        1, 1, 0, 2);
        vecs[5]  = mk(MEM_OP_LOAD,  32'h600, 32'h0,        5'd3,  0, 2, 1, 1, 0, 32'h11112222, 1, 0, 0, 5);
        vecs[6]  = mk(MEM_OP_LOAD,  32'h700, 32'h0,        5'd30, 0, 0, 1, 2, 0, 32'h33334444, 1, 0, 0, 3);
        vecs[7]  = mk(MEM_OP_LOAD,  32'h800, 32'h0,        5'd0,  0, 0, 1, 0, 0, 32'hFFFFFFFF, 1, 0, 1, 3);
        vecs[8]  = mk(MEM_OP_STORE, 32'hAA0, 32'h5555AAAA, 5'd9,  0, 2, 1, 0, 1, 32'h0,        1, 1, 0, 4);
        vecs[9]  = mk(MEM_OP_LOAD,  32'hB00, 32'h0,        5'd20, 0, 0, 2, 0, 2, 32'h0F0F0F0F, 1, 0, 1, 4);
        vecs[10] = mk(MEM_OP_STORE, 32'hC00, 32'h77778888, 5'd17, 0, 1, 1, 1, 0, 32'h0,        1, 1, 0, 3);

        reset                 = 1'b1;
        fire_memory_op        = 1'b0;
        memory_op_type        = MEM_OP_LOAD;
        memory_address        = '0;
        memory_data           = '0;
        ldq_mem_stage_index   = '0;
        stq_mem_stage_index   = '0;
        flush                 = 1'b0;
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_rdata = '0;
        tick();
        tick();
        check("rst_port_ready", port_ready, 1);
        check("rst_req_valid", mem_if.mem_req_valid, 0);
        check("rst_req_addr", mem_if.mem_req_addr, 0);
        check("rst_store_done", store_done_valid, 0);
        check("rst_load_result", load_result_valid, 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_txn(vecs[i]);

        // Reset in the middle of a store request.
        fire_memory_op      = 1'b1;
        memory_op_type      = MEM_OP_STORE;
        memory_address      = 32'h900;
        memory_data         = 32'h33333333;
        stq_mem_stage_index = 5'd3;
        tick();
        fire_memory_op = 1'b0;
        check("mid_store_req_valid", mem_if.mem_req_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_req_valid", mem_if.mem_req_valid, 0);
        check("async_rst_port_ready", port_ready, 1);
        check("async_rst_addr", mem_if.mem_req_addr, 0);
        check("async_rst_wdata", mem_if.mem_req_wdata, 0);
        check("async_rst_write", mem_if.mem_req_write, 0);
        mem_if.mem_req_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_if.mem_resp_valid = (c == 0);
            mem_if.mem_resp_rdata = 32'hBAD0BAD0;
            tick();
            check("post_rst_no_store_done", store_done_valid, 0);
            check("post_rst_no_load_result", load_result_valid, 0);
            check("post_rst_no_req", mem_if.mem_req_valid, 0);
        end
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        run_txn(mk(MEM_OP_LOAD, 32'hD00, 32'h0, 5'd11, 0, 1, 2, 0, 0, 32'hA5A5A5A5, 1, 0, 1, 5));

        // Random transactions against the rule model.
        for (int n = 0; n < 60; n++) begin
            v.op         = ($urandom_range(0, 1) == 1) ? MEM_OP_STORE : MEM_OP_LOAD;
            v.addr       = $urandom;
            v.wdata      = $urandom;
            v.idx        = IW'($urandom);
            v.flush_fire = ($urandom_range(0, 5) == 0);
            v.stall      = $urandom_range(0, 4);
            v.resp_dly   = $urandom_range(1, 4);
            v.flush_k    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, v.stall + 1 + v.resp_dly) : 0;
            v.refire_k   = 0;
            v.rdata      = $urandom;
            run_txn(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lsu_memory_port.md
# lsu_memory_port

Registered bridge between the LSU's memory-op selection logic and the data-memory bus. It captures one load or store per `fire_memory_op` and drives a valid/ready request to memory. Load responses return tagged with their load-queue index; store completion returns tagged with its store-queue index. It holds at most one operation in flight, advertises `port_ready` back to the selector, and suppresses load results killed by a pipeline flush.

## Interface
- `XLEN`, 32, data/address width
- `LDQ_SIZE`, 32, load queue entries; index width `$clog2(LDQ_SIZE)`
- `STQ_SIZE`, 32, store queue entries; index width `$clog2(STQ_SIZE)`

- `clk`  in  1  sole clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `fire_memory_op`  in  1  selector issues an op this cycle
- `memory_op_type`  in  1  0 = load, 1 = store
- `memory_address`  in  XLEN  byte address
- `memory_data`  in  XLEN  store data (ignored for loads)
- `ldq_mem_stage_index`  in  clog2(LDQ_SIZE)  load index, valid with a load fire
- `stq_mem_stage_index`  in  clog2(STQ_SIZE)  store index, valid with a store fire
- `flush`  in  1  misprediction/exception flush; kills outstanding load
- `port_ready`  out  1  high when a fire will be accepted this cycle
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_write`  out  1  1 = store
- `mem_req_addr`  out  XLEN  request address
- `mem_req_wdata`  out  XLEN  store data
- `mem_resp_valid`  in  1  load data returning
- `mem_resp_rdata`  in  XLEN  load data
- `load_result_valid`  out  1  one-cycle pulse: load data for `load_result_index`
- `load_result_index`  out  clog2(LDQ_SIZE)  load queue index
- `load_result_data`  out  XLEN  loaded word
- `store_done_valid`  out  1  one-cycle pulse: store accepted by memory
- `store_done_index`  out  clog2(STQ_SIZE)  store queue index

## Operation
- FSM states: IDLE, REQ, WAIT.
- `port_ready` = (state == IDLE).
- IDLE: on `fire_memory_op`, latch type, address, data and the matching index, then go to REQ. Exception: a load fire in the same cycle as `flush` is dropped and the FSM stays in IDLE. A store fire with `flush` is latched, because stores are committed.
- REQ: `mem_req_valid`=1. Request fields come from the latch and stay stable until accepted. When `mem_req_ready` is seen:
  - store: pulse `store_done_valid` next cycle, go to IDLE.
  - load: go to WAIT.
- WAIT: on `mem_resp_valid`, register `load_result_*` and go to IDLE. Suppress `load_result_valid` if `killed` is set.
- `killed`:
  - Set by `flush` while a load is in REQ or WAIT.
  - Cleared when the FSM enters IDLE.
  - A killed load in REQ still completes its handshake. Valid is never retracted.
- `mem_resp_valid` outside WAIT is ignored.
- `fire_memory_op` while `port_ready`=0 is a protocol violation. It is ignored and flagged by a simulation assertion.
- Flush in the same cycle as the response arrives: the result is suppressed.

## Timing
- All outputs except `port_ready` are registered. `port_ready` decodes state directly.
- Reset values: state IDLE, `killed`=0, all `*_valid` outputs 0, all latched address/data/index registers 0.
- Fire at T → `mem_req_valid` at T+1.
- Store, ready at T+1 → `store_done_valid` at T+2 and `port_ready` at T+2.
- Load, ready at T+1, response at T+2 → `load_result_valid` at T+3 and `port_ready` at T+3. Minimum load latency is 3 cycles.
- Back-to-back throughput: a store every 2 cycles; a load every 3 cycles minimum.
- `store_done_valid` and `load_result_valid` are each high for exactly one cycle and never high together.
- Reset asserted mid-operation returns to IDLE immediately. There is no pending pulse afterwards, and a later stray `mem_resp_valid` is ignored.

## Structure
- Shared `lsu_pkg`:
  - `mem_op_t` enum (`MEM_OP_LOAD`=0, `MEM_OP_STORE`=1), also used by the selector.
  - `lsu_port_state_t` enum (IDLE, REQ, WAIT).
- Single module; no sub-module is warranted.

## Test plan
- Store fire at T (addr 0x100, data 0xDEADBEEF, stq idx 5), `mem_req_ready` tied 1:
  - T+1: `mem_req_valid`=1, `mem_req_write`=1, addr 0x100, data 0xDEADBEEF.
  - T+2: `store_done_valid`=1 with index 5.
- Load fire (addr 0x200, ldq idx 7), `mem_req_ready` held 0 for 3 cycles, then response 0x12345678 two cycles after acceptance:
  - Request fields stay stable while stalled.
  - `load_result_valid`=1, index 7, data 0x12345678, one cycle after the response.
- Load in WAIT, `flush` pulsed, then response arrives → no `load_result_valid`; `port_ready`=1 the following cycle.
- Load fire and `flush` in the same cycle from IDLE → no `mem_req_valid`; `port_ready` stays 1.
- Reset asserted during REQ of a store (stq idx 3), then released → all outputs 0, no `store_done_valid`; a subsequent load completes normally.
- Fire while `port_ready`=0 → ignored; the in-flight op completes unchanged and the assertion fires.
